uart_apb_master_slave: RTL and testbench
========================================

// Module: uart_apb_master_slave
// PURPOSE
// - APB bridge in front of the UART: an internal APB master issues one transfer per request, and an internal APB slave holds the UART registers.
// - Write data for the TX register drives totx and fires the start strobe s.
// - Received words (fromrx/rxdone) are captured and can be read back over APB on apb_read_data_outu.
// PARAMETERS
// - ADDR_W   32  width of apb_write_paddr / apb_read_paddr
// - DATA_W   32  width of all data buses
// - REG_AW    2  address LSBs decoded by slave (word index = paddr[REG_AW-1:0])
// PORTS
// - PCLK              in   1       clock, rising edge
// - PRESETn           in   1       asynchronous reset, ACTIVE-HIGH (1 = reset)
// - transfer          in   1       request; sampled in IDLE and at end of ACCESS
// - READ_WRITE        in   1       0 = write, 1 = read; sampled when leaving IDLE/ACCESS
// - PSEL1             in   1       slave select enable; 0 = slave ignores transfer
// - apb_write_paddr   in   ADDR_W  write address
// - apb_read_paddr    in   ADDR_W  read address
// - apb_write_data    in   DATA_W  write data
// - rxdone            in   1       one-cycle pulse: fromrx valid
// - fromrx            in   DATA_W  word from UART receiver
// - apb_read_data_outu out DATA_W registered read result
// - totx              out DATA_W  TX data register contents
// - s                 out 1       one-cycle TX start strobe
// BEHAVIOUR
// - Reset values: master FSM = IDLE; totx = 0; apb_read_data_outu = 0; s = 0; RXDATA = 0; rx_valid = 0; CTRL = 0.
// - Master FSM states:
//   - IDLE -> SETUP when transfer=1. Latch cmd: READ_WRITE, addr (write or read paddr per READ_WRITE), wdata.
//   - SETUP -> ACCESS always, with PENABLE=0.
//   - ACCESS with PREADY=1: transfer completes. Next state is SETUP if transfer=1 (new cmd latched), else IDLE.
//   - ACCESS with PREADY=0: stay in ACCESS.
// - Without wait states, a transfer completes on the 2nd rising edge after transfer is sampled.
// - Held transfer = back-to-back transfers every 2 cycles.
// - Internal PSEL = PSEL1 & (state != IDLE). With PSEL1=0:
//   - transfer still completes.
//   - Writes have no effect.
//   - Reads return 0.
// - Slave map (word index):
//   - 0 RXDATA: RO.
//   - 1 TXDATA: RW, equals totx.
//   - 2 STATUS: RO, bit0 = rx_valid, rest 0.
//   - 3 CTRL: RW scratch.
// - Writes to RO registers are ignored.
// - Address bits above REG_AW are ignored (aliasing).
// - Write completion:
//   - Selected register is updated on the completing edge.
//   - A write to TXDATA also sets s=1 for exactly that next cycle. Every completed TXDATA write pulses s, even with equal data.
// - Read completion: apb_read_data_outu <= register value on the completing edge; it holds until the next read.
// - rxdone=1: RXDATA <= fromrx and rx_valid <= 1, independent of the FSM.
// - Completed read of RXDATA clears rx_valid. If rxdone occurs in the same cycle, the set wins and RXDATA takes the new word.
// - Reset asserted mid-transfer: FSM goes to IDLE immediately, the transfer is lost, and all outputs take reset values.
// CONFIGURATION
// - WAIT_STATE_EN defined:
//   - Slave drives PREADY=0 on the first ACCESS cycle of every transfer, so completion takes 3 edges.
//   - Back-to-back transfers occur every 3 cycles.
// - WAIT_STATE_EN undefined: PREADY is tied 1.
// TESTING
// - Reset, then PRESETn=0, PSEL1=1, write addr 1, data 32'h12345678, transfer=1 -> within 10 cycles totx==32'h12345678 and s pulsed high for 1 cycle.
// - rxdone pulse with fromrx=32'hFFFFFFFF, then read addr 2 -> outu==1. Read addr 0 -> outu==32'hFFFFFFFF. Read addr 2 again -> outu==0.
// - PSEL1=0, write addr 1 data 32'hA5A5A5A5 -> totx unchanged and s stays 0. Read addr 1 -> outu==0.
// - Write addr 0 data 32'h1 (RO) -> RXDATA unchanged. Write addr 3 data 32'hCAFEBABE, then read addr 3 -> 32'hCAFEBABE.
// - Assert PRESETn during ACCESS of a TXDATA write -> totx=0, s=0, FSM in IDLE; after release, no write completes.
// - Hold transfer=1, alternating data 1,2 to addr 1 -> s pulses every 2 cycles (3 cycles with WAIT_STATE_EN), and totx follows the data.

Source files
------------

// File: rtl/uart_apb_master_slave.sv
// APB master/slave bridge in front of the UART: TX register, RX capture, status and scratch.
// Optional build macro WAIT_STATE_EN inserts one PREADY=0 cycle at the start of every ACCESS phase.
module uart_apb_master_slave #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int REG_AW = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              transfer,
   input  logic              READ_WRITE,
   input  logic              PSEL1,
   input  logic [ADDR_W-1:0] apb_write_paddr,
   input  logic [ADDR_W-1:0] apb_read_paddr,
   input  logic [DATA_W-1:0] apb_write_data,
   input  logic              rxdone,
   input  logic [DATA_W-1:0] fromrx,
   output logic [DATA_W-1:0] apb_read_data_outu,
   output logic [DATA_W-1:0] totx,
   output logic              s
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   localparam logic [REG_AW-1:0] IDX_RXDATA = REG_AW'(0);
   localparam logic [REG_AW-1:0] IDX_TXDATA = REG_AW'(1);
   localparam logic [REG_AW-1:0] IDX_STATUS = REG_AW'(2);
   localparam logic [REG_AW-1:0] IDX_CTRL   = REG_AW'(3);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              cmd_rw;
   logic [REG_AW-1:0] cmd_idx;
   logic [DATA_W-1:0] cmd_wdata;
   logic [DATA_W-1:0] rxdata;
   logic              rx_valid;
   logic [DATA_W-1:0] ctrl;
   logic              psel;
   logic              penable;
   logic              pready;
   logic              xfer_done;
   logic              cmd_load;
   logic              wr_en;
   logic              rd_en;
   logic [DATA_W-1:0] rd_mux;
   logic [REG_AW-1:0] req_idx;
   logic              unused_addr_hi;

   // Only the word index is kept; upper address bits alias onto the register map.
   assign req_idx        = READ_WRITE ? apb_read_paddr[REG_AW-1:0] : apb_write_paddr[REG_AW-1:0];
   assign unused_addr_hi = ^{apb_read_paddr[ADDR_W-1:REG_AW], apb_write_paddr[ADDR_W-1:REG_AW]};

   assign psel    = PSEL1 & (state != IDLE);
   assign penable = (state == ACCESS);

`ifdef WAIT_STATE_EN
   logic wait_pend;

   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) wait_pend <= 1'b0;
      else         wait_pend <= (state == SETUP);
   end

   assign pready = ~wait_pend;
`else
   assign pready = 1'b1;
`endif

   assign xfer_done = penable & pready;
   assign cmd_load  = transfer & ((state == IDLE) | xfer_done);
   assign wr_en     = psel & xfer_done & ~cmd_rw;
   assign rd_en     = psel & xfer_done & cmd_rw;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (transfer) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pready) state_nxt = transfer ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         cmd_rw    <= 1'b0;
         cmd_idx   <= '0;
         cmd_wdata <= '0;
      end else if (cmd_load) begin
         cmd_rw    <= READ_WRITE;
         cmd_idx   <= req_idx;
         cmd_wdata <= apb_write_data;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (cmd_idx)
         IDX_RXDATA: rd_mux = rxdata;
         IDX_TXDATA: rd_mux = totx;
         IDX_STATUS: rd_mux = {{(DATA_W-1){1'b0}}, rx_valid};
         IDX_CTRL:   rd_mux = ctrl;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         totx <= '0;
         s    <= 1'b0;
         ctrl <= '0;
      end else begin
         s <= wr_en & (cmd_idx == IDX_TXDATA);
         if (wr_en && cmd_idx == IDX_TXDATA) totx <= cmd_wdata;
         if (wr_en && cmd_idx == IDX_CTRL)   ctrl <= cmd_wdata;
      end
   end

   // A deselected read still completes but returns zero.
   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn)                     apb_read_data_outu <= '0;
      else if (xfer_done && cmd_rw)    apb_read_data_outu <= psel ? rd_mux : '0;
   end

   // A new word arriving on the same edge as an RXDATA read keeps rx_valid set.
   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         rxdata   <= '0;
         rx_valid <= 1'b0;
      end else if (rxdone) begin
         rxdata   <= fromrx;
         rx_valid <= 1'b1;
      end else if (rd_en && cmd_idx == IDX_RXDATA) begin
         rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_apb_master_slave.sv
// Self-checking bench for uart_apb_master_slave: transaction-level register model plus random traffic.
module tb_uart_apb_master_slave;

`ifdef WAIT_STATE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        PCLK;
   logic        PRESETn;
   logic        transfer;
   logic        READ_WRITE;
   logic        PSEL1;
   logic [31:0] apb_write_paddr;
   logic [31:0] apb_read_paddr;
   logic [31:0] apb_write_data;
   logic        rxdone;
   logic [31:0] fromrx;
   logic [31:0] apb_read_data_outu;
   logic [31:0] totx;
   logic        s;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] m_totx, m_ctrl, m_rxdata, m_outu;
   logic        m_rxvalid;

   uart_apb_master_slave #(.ADDR_W(32), .DATA_W(32), .REG_AW(2)) dut (
      .PCLK               (PCLK),
      .PRESETn            (PRESETn),
      .transfer           (transfer),
      .READ_WRITE         (READ_WRITE),
      .PSEL1              (PSEL1),
      .apb_write_paddr    (apb_write_paddr),
      .apb_read_paddr     (apb_read_paddr),
      .apb_write_data     (apb_write_data),
      .rxdone             (rxdone),
      .fromrx             (fromrx),
      .apb_read_data_outu (apb_read_data_outu),
      .totx               (totx),
      .s                  (s)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_reg(input logic [1:0] idx);
      case (idx)
         2'd0:    return m_rxdata;
         2'd1:    return m_totx;
         2'd2:    return {31'd0, m_rxvalid};
         default: return m_ctrl;
      endcase
   endfunction

   task automatic m_reset();
      m_totx = '0; m_ctrl = '0; m_rxdata = '0; m_outu = '0; m_rxvalid = 1'b0;
   endtask

   task automatic rx_pulse(input logic [31:0] w);
      @(negedge PCLK);
      rxdone = 1'b1; fromrx = w;
      @(negedge PCLK);
      rxdone = 1'b0;
      m_rxdata = w; m_rxvalid = 1'b1;
   endtask

   // One isolated transfer; optionally an rxdone pulse lands on the completing edge.
   task automatic xfer(input bit rw, input logic [31:0] addr, input logic [31:0] wd,
                       input bit sel, input bit rx_same, input logic [31:0] rxw);
      logic [1:0]  idx;
      logic        exp_s;
      idx   = addr[1:0];
      exp_s = 1'b0;
      @(negedge PCLK);
      READ_WRITE      = rw;
      apb_write_paddr = rw ? $urandom : addr;
      apb_read_paddr  = rw ? addr : $urandom;
      apb_write_data  = wd;
      PSEL1           = sel;
      transfer        = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      transfer = 1'b0;
      repeat (LAT - 1) @(negedge PCLK);
      if (rx_same) begin
         rxdone = 1'b1; fromrx = rxw;
      end
      @(posedge PCLK);
      #1;
      rxdone = 1'b0;
      if (sel) begin
         if (!rw) begin
            if (idx == 2'd1) begin m_totx = wd; exp_s = 1'b1; end
            if (idx == 2'd3) m_ctrl = wd;
         end else begin
            m_outu = m_reg(idx);
            if (idx == 2'd0) m_rxvalid = 1'b0;
         end
      end else if (rw) begin
         m_outu = '0;
      end
      if (rx_same) begin m_rxdata = rxw; m_rxvalid = 1'b1; end
      check(rw ? "rd_outu" : "wr_outu", apb_read_data_outu, m_outu);
      check("totx", totx, m_totx);
      check("s_done", {31'd0, s}, {31'd0, exp_s});
      @(posedge PCLK);
      #1;
      check("s_after", {31'd0, s}, 32'd0);
   endtask

   task automatic burst(input int unsigned n);
      logic [31:0] d [];
      d = new[n];
      for (int unsigned k = 0; k < n; k++) d[k] = (k % 2 == 0) ? 32'd1 : 32'd2;
      @(negedge PCLK);
      READ_WRITE = 1'b0; apb_write_paddr = 32'h1; PSEL1 = 1'b1;
      apb_write_data = d[0]; transfer = 1'b1;
      for (int unsigned k = 0; k < n; k++) begin
         @(posedge PCLK);
         #1;
         if (k > 0) begin
            m_totx = d[k-1];
            check("burst_s", {31'd0, s}, 32'd1);
            check("burst_totx", totx, m_totx);
         end
         if (k == n - 1) transfer = 1'b0;
         else            apb_write_data = d[k+1];
         repeat (LAT - 1) begin
            @(posedge PCLK);
            #1;
            check("burst_s_gap", {31'd0, s}, 32'd0);
            check("burst_totx_gap", totx, m_totx);
         end
      end
      @(posedge PCLK);
      #1;
      m_totx = d[n-1];
      check("burst_s_last", {31'd0, s}, 32'd1);
      check("burst_totx_last", totx, m_totx);
      @(posedge PCLK);
      #1;
      check("burst_s_end", {31'd0, s}, 32'd0);
   endtask

   task automatic reset_mid_access();
      @(negedge PCLK);
      READ_WRITE = 1'b0; apb_write_paddr = 32'h1; apb_write_data = 32'hDEAD0001;
      PSEL1 = 1'b1; transfer = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      transfer = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      #1;
      m_reset();
      check("rst_totx", totx, 32'd0);
      check("rst_s", {31'd0, s}, 32'd0);
      check("rst_outu", apb_read_data_outu, 32'd0);
      @(negedge PCLK);
      PRESETn = 1'b0;
      repeat (LAT + 2) begin
         @(posedge PCLK);
         #1;
         check("post_rst_s", {31'd0, s}, 32'd0);
         check("post_rst_totx", totx, 32'd0);
      end
   endtask

   initial begin
      logic [1:0]  idx;
      logic [31:0] a;
      PRESETn = 1'b1; transfer = 1'b0; READ_WRITE = 1'b0; PSEL1 = 1'b0;
      apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0;
      rxdone = 1'b0; fromrx = '0;
      m_reset();
      repeat (3) @(negedge PCLK);
      check("reset_totx", totx, 32'd0);
      check("reset_outu", apb_read_data_outu, 32'd0);
      check("reset_s", {31'd0, s}, 32'd0);
      PRESETn = 1'b0;

      xfer(0, 32'h1, 32'h12345678, 1, 0, 0);
      rx_pulse(32'hFFFFFFFF);
      xfer(1, 32'h2, 0, 1, 0, 0);
      xfer(1, 32'h0, 0, 1, 0, 0);
      xfer(1, 32'h2, 0, 1, 0, 0);
      xfer(0, 32'h1, 32'hA5A5A5A5, 0, 0, 0);
      xfer(1, 32'h1, 0, 0, 0, 0);
      xfer(0, 32'h0, 32'h1, 1, 0, 0);
      xfer(1, 32'h0, 0, 1, 0, 0);
      xfer(0, 32'h3, 32'hCAFEBABE, 1, 0, 0);
      xfer(1, 32'h0000_0107, 0, 1, 0, 0);
      xfer(0, 32'h1, 32'h12345678, 1, 0, 0);
      rx_pulse(32'h0BADF00D);
      xfer(1, 32'h0, 0, 1, 1, 32'h5EED5EED);
      xfer(1, 32'h2, 0, 1, 0, 0);
      xfer(1, 32'h0, 0, 1, 0, 0);

      burst(6);
      reset_mid_access();
      xfer(1, 32'h1, 0, 1, 0, 0);
      xfer(1, 32'h3, 0, 1, 0, 0);

      for (int unsigned i = 0; i < 80; i++) begin
         idx = 2'($urandom_range(0, 3));
         a   = ($urandom & 32'hFFFF_FFFC) | {30'd0, idx};
         if ($urandom_range(0, 4) == 0) rx_pulse($urandom);
         xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) == 0, $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
